// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

    // Bulk-clear engine states.
    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

    // Hard-wired zero register index.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: a new producer (set) beats a completing
// write (clear) to the same register; a bulk clear beats both.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr_all,
    input  logic                                 set_en,
    input  logic [ADDR_WIDTH-1:0]                set_addr,
    input  logic [NUM_WR-1:0]                    wr_clr_en,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_clr_addr,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr,
    output logic [NUM_RD-1:0]                    rd_pending
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Next pending vector: write clears first, then set, then bulk clear.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pend_d = pend_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_clr_en[p] && wr_clr_addr[p] != ZERO_IDX) begin
                pend_d[wr_clr_addr[p]] = 1'b0;
            end
        end
        if (set_en && set_addr != ZERO_IDX) begin
            pend_d[set_addr] = 1'b1;
        end
        if (clr_all) begin
            pend_d = '0;
        end
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Registered lookups only; bit 0 is never set so x0 is never pending.
    always_comb begin
        rd_pending = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_pending[i] = pend_q[rd_addr[i]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass,
// pending scoreboard and a sequenced bulk-clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int BYPASS     = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]                    rd_pending,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wr_data,
    input  logic                                 sb_set_en,
    input  logic [ADDR_WIDTH-1:0]                sb_set_addr,
    input  logic                                 clr_req,
    output logic                                 clr_busy
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    clr_state_e            state_q;
    clr_state_e            state_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  clearing;
    logic                  clr_start;
    logic [NUM_WR-1:0]     wr_live;
    logic                  sb_set_live;

    assign clearing    = (state_q == CLR_RUN);
    assign clr_start   = (state_q == CLR_IDLE) && clr_req;
    assign wr_live     = clearing ? '0 : wr_en;
    assign sb_set_live = sb_set_en && !clearing;
    assign clr_busy    = clearing;

    // Clear FSM next-state: start on request, finish after the last index.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_IDLE: if (clr_req)           state_d = CLR_RUN;
            CLR_RUN:  if (idx_q == LAST_IDX) state_d = CLR_IDLE;
            default:                         state_d = CLR_IDLE;
        endcase
    end

    // Clear FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CLR_IDLE;
        else        state_q <= state_d;
    end

    // Sweep index: starts at x1, parks at 0 once the sweep ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (clr_start) begin
            idx_q <= ONE_IDX;
        end else if (clearing) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + ONE_IDX;
        end
    end

    // Register array: sweep owns the array while clearing, else ports write
    // in order so the highest-numbered port wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset here because architectural state must read 0 after reset; this costs a reset net per flop.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (clearing) begin
            regs[idx_q] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_addr[p] != ZERO_IDX) begin
                    regs[wr_addr[p]] <= wr_data[p];
                end
            end
        end
    end

    // Read ports: array value, overridden by the winning same-cycle write.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i] != ZERO_IDX) begin
                rd_data[i] = regs[rd_addr[i]];
                if (BYPASS != 0 && !clearing) begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (wr_en[p] && wr_addr[p] == rd_addr[i]) begin
                            rd_data[i] = wr_data[p];
                        end
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .NUM_WR     (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_all     (clr_start),
        .set_en      (sb_set_live),
        .set_addr    (sb_set_addr),
        .wr_clr_en   (wr_live),
        .wr_clr_addr (wr_addr),
        .rd_addr     (rd_addr),
        .rd_pending  (rd_pending)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a 2-read/2-write bypassing instance
// checked against a behavioural model, plus a 1/1 non-bypassing instance.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: NUM_RD=2, NUM_WR=2, BYPASS=1.
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_pending;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             sb_set_en;
    logic [4:0]       sb_set_addr;
    logic             clr_req;
    logic             clr_busy;

    // Secondary instance: NUM_RD=1, NUM_WR=1, BYPASS=0.
    logic [0:0][4:0]  b_rd_addr;
    logic [0:0][31:0] b_rd_data;
    logic [0:0]       b_rd_pending;
    logic [0:0]       b_wr_en;
    logic [0:0][4:0]  b_wr_addr;
    logic [0:0][31:0] b_wr_data;
    logic             b_sb_set_en;
    logic [4:0]       b_sb_set_addr;
    logic             b_clr_req;
    logic             b_clr_busy;

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .clr_req(clr_req),
        .clr_busy(clr_busy)
    );

    regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(1), .NUM_WR(1), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_pending(b_rd_pending), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .sb_set_en(b_sb_set_en), .sb_set_addr(b_sb_set_addr), .clr_req(b_clr_req),
        .clr_busy(b_clr_busy)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model of the main instance.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    int          m_sweep;   // 0 = not sweeping, else next index the sweep zeroes

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        m_sweep = 0;
    endfunction

    // Apply one clock edge's worth of architectural effect from current inputs.
    function automatic void model_step();
        if (m_sweep != 0) begin
            m_regs[m_sweep] = '0;
            m_sweep = (m_sweep == 31) ? 0 : m_sweep + 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p] != 0) begin
                    m_regs[wr_addr[p]] = wr_data[p];
                    m_pend[wr_addr[p]] = 1'b0;
                end
            end
            if (sb_set_en && sb_set_addr != 0) m_pend[sb_set_addr] = 1'b1;
            if (clr_req) begin
                for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
                m_sweep = 1;
            end
        end
    endfunction

    // Expected combinational read value for the main instance.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        if (m_sweep == 0) begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p] == a) v = wr_data[p];
            end
        end
        return v;
    endfunction

    task automatic drive_idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0; clr_req = 1'b0;
        b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
        b_sb_set_en = 1'b0; b_sb_set_addr = '0; b_clr_req = 1'b0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_index_values();
        for (int r = 1; r < 32; r++) begin
            wr_en = 2'b01; wr_addr[0] = 5'(r); wr_data[0] = 32'(r);
            cycle();
        end
        wr_en = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a); rd_addr[1] = 5'(31 - a);
            #1;
            tests_run++;
            if (rd_data !== '0 || rd_pending !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_read x%0d: got data=%h pend=%b, want 0/00", a, rd_data, rd_pending);
            end
        end
        tests_run++;
        if (clr_busy !== 1'b0 || b_clr_busy !== 1'b0 || b_rd_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got busy=%b b_busy=%b b_pend=%b, want 0", clr_busy, b_clr_busy, b_rd_pending);
        end
        rd_addr = '0;
        cycle();
    endtask

    task automatic test_bypass();
        // Bypassing instance: same-cycle read returns new data.
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd5;
        // Non-bypassing instance: same-cycle read returns old contents.
        b_wr_en = 1'b1; b_wr_addr[0] = 5'd5; b_wr_data[0] = 32'hDEADBEEF; b_rd_addr[0] = 5'd5;
        #1;
        tests_run++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle: got %h want deadbeef", rd_data[0]);
        end
        tests_run++;
        if (b_rd_data[0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL nobypass_same_cycle: got %h want 0", b_rd_data[0]);
        end
        cycle();
        wr_en = '0; b_wr_en = '0;
        #1;
        tests_run++;
        if (b_rd_data[0] !== 32'hDEADBEEF || rd_data[0] !== exp_read(5'd5)) begin
            tests_failed++;
            $display("FAIL write_next_cycle: got b=%h a=%h want deadbeef", b_rd_data[0], rd_data[0]);
        end
        // Writes to x0 are dropped and never forwarded.
        wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h1; rd_addr[0] = 5'd0;
        #1;
        tests_run++;
        if (rd_data[0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL x0_bypass: got %h want 0", rd_data[0]);
        end
        cycle();
        wr_en = '0;
        #1;
        tests_run++;
        if (rd_data[0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL x0_write: got %h want 0", rd_data[0]);
        end
    endtask

    task automatic test_dual_write();
        wr_en = 2'b11; wr_addr[0] = 5'd7; wr_data[0] = 32'h11;
        wr_addr[1] = 5'd7; wr_data[1] = 32'h22; rd_addr[1] = 5'd7;
        #1;
        tests_run++;
        if (rd_data[1] !== 32'h22) begin
            tests_failed++;
            $display("FAIL dual_write_bypass: got %h want 22", rd_data[1]);
        end
        cycle();
        wr_en = '0;
        #1;
        tests_run++;
        if (rd_data[1] !== 32'h22) begin
            tests_failed++;
            $display("FAIL dual_write_stored: got %h want 22", rd_data[1]);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr[0] = 5'd9;
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        cycle();
        sb_set_en = 1'b0;
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99;
        #1;
        tests_run++;
        if (rd_pending[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_set: got %b want 1", rd_pending[0]);
        end
        cycle();
        wr_en = '0;
        #1;
        tests_run++;
        if (rd_pending[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_clear_by_write: got %b want 0", rd_pending[0]);
        end
        // Set and write together: the new producer wins.
        sb_set_en = 1'b1; sb_set_addr = 5'd9;
        wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'hAA;
        cycle();
        sb_set_en = 1'b0; wr_en = '0;
        #1;
        tests_run++;
        if (rd_pending[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_set_wins: got %b want 1", rd_pending[0]);
        end
        // sb_set to x0 is dropped.
        sb_set_en = 1'b1; sb_set_addr = 5'd0; rd_addr[1] = 5'd0;
        cycle();
        sb_set_en = 1'b0;
        #1;
        tests_run++;
        if (rd_pending[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_x0: got %b want 0", rd_pending[1]);
        end
    endtask

    task automatic test_clear();
        int n;
        fill_index_values();
        sb_set_en = 1'b1; sb_set_addr = 5'd4;
        cycle();
        sb_set_en = 1'b0;
        clr_req = 1'b1; rd_addr[0] = 5'd4;
        #1;
        tests_run++;
        if (rd_pending[0] !== 1'b1 || clr_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_pre: got pend=%b busy=%b want 1/0", rd_pending[0], clr_busy);
        end
        cycle();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 40) begin
            if (n == 5) begin
                wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'hFF;
                sb_set_en = 1'b1; sb_set_addr = 5'd3; clr_req = 1'b1;
                rd_addr[0] = 5'd3;
                #1;
                tests_run++;
                if (rd_data[0] !== exp_read(5'd3)) begin
                    tests_failed++;
                    $display("FAIL clear_no_bypass: got %h want %h", rd_data[0], exp_read(5'd3));
                end
            end
            cycle();
            wr_en = '0; sb_set_en = 1'b0; clr_req = 1'b0;
            n++;
        end
        tests_run++;
        if (n != 31) begin
            tests_failed++;
            $display("FAIL clear_busy_len: got %0d cycles want 31", n);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a); rd_addr[1] = 5'(a);
            #1;
            tests_run++;
            if (rd_data[0] !== 32'h0 || rd_pending !== 2'b00) begin
                tests_failed++;
                $display("FAIL clear_result x%0d: got data=%h pend=%b want 0/00", a, rd_data[0], rd_pending);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        fill_index_values();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int c = 0; c < 40 && m_sweep != 10; c++) cycle();
        rd_addr[0] = 5'd20; rd_addr[1] = 5'd25;
        #1;
        tests_run++;
        if (rd_data[0] !== 32'h14 || clr_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sweep_pre_reset: got x20=%h busy=%b want 14/1", rd_data[0], clr_busy);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (rd_data !== '0 || clr_busy !== 1'b0 || rd_pending !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_in_sweep: got data=%h busy=%b pend=%b want 0", rd_data, clr_busy, rd_pending);
        end
        #1 rst_n = 1'b1;
        cycle();
        tests_run++;
        if (clr_busy !== 1'b0 || rd_data[0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL after_reset_idle: got busy=%b x20=%h want 0/0", clr_busy, rd_data[0]);
        end
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rd_addr[0] = rand_addr(); rd_addr[1] = rand_addr();
            wr_en = 2'($urandom_range(0, 3));
            wr_addr[0] = rand_addr(); wr_addr[1] = rand_addr();
            wr_data[0] = $urandom(); wr_data[1] = $urandom();
            sb_set_en = ($urandom_range(0, 2) == 0);
            sb_set_addr = rand_addr();
            clr_req = ($urandom_range(0, 59) == 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (rd_data[i] !== exp_read(rd_addr[i]) || rd_pending[i] !== m_pend[rd_addr[i]]) begin
                    tests_failed++;
                    $display("FAIL random c%0d port%0d x%0d: got data=%h pend=%b want %h/%b",
                             c, i, rd_addr[i], rd_data[i], rd_pending[i], exp_read(rd_addr[i]), m_pend[rd_addr[i]]);
                end
            end
            tests_run++;
            if (clr_busy !== (m_sweep != 0)) begin
                tests_failed++;
                $display("FAIL random_busy c%0d: got %b want %b", c, clr_busy, (m_sweep != 0));
            end
            cycle();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
